// File: rtl/barrel_shift_pkg.sv
// Shared FSM encoding and default geometry for the two-requester rotate arbiter.
package barrel_shift_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int AMT_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/Barrel_Shift_R_Gen.sv
// Combinational rotate-right: one log2 stage per amount bit, no state, no backpressure.
module Barrel_Shift_R_Gen #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic [WIDTH-1:0] num,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] shifted
);

   logic [WIDTH-1:0] acc;

   // Stage i rotates by 2**i when amt[i] is set; the stages compose to a rotate by amt.
   always_comb begin
      acc = num;
      for (int i = 0; i < AMT_W; i++) begin
         if (amt[i]) begin
            acc = (acc >> (1 << i)) | (acc << (WIDTH - (1 << i)));
         end
      end
   end

   assign shifted = acc;

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter feeding a rotate unit; accept on T gives out_valid on T+3.
// Requesters stall (ready low) whenever the FSM is not IDLE; the result holds until out_ready.
module barrel_shift_arbiter
   import barrel_shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AMT_W = AMT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_num,
   input  logic [AMT_W-1:0] req0_amt,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_num,
   input  logic [AMT_W-1:0] req1_amt,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_id,
   input  logic             out_ready,
   output logic             busy
);

   state_t           state;
   state_t           state_nxt;
   logic             ptr;
   logic             grant_any;
   logic             grant_id;
   logic [WIDTH-1:0] cap_num;
   logic [AMT_W-1:0] cap_amt;
   logic             cap_id;
   logic [WIDTH-1:0] shifted;

   // ptr == 1 means requester 1 wins a tie.
   assign grant_any = req0_valid | req1_valid;
   assign grant_id  = req1_valid & (~req0_valid | ptr);

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any && !rst) begin
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_nxt  = LOAD;
            end
         end
         LOAD:    state_nxt = SHIFT;
         SHIFT:   state_nxt = OUT;
         OUT: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= 1'b0;
         cap_num  <= '0;
         cap_amt  <= '0;
         cap_id   <= 1'b0;
         out_data <= '0;
         out_id   <= 1'b0;
      end else begin
         if (state == IDLE && grant_any) begin
            cap_num <= grant_id ? req1_num : req0_num;
            cap_amt <= grant_id ? req1_amt : req0_amt;
            cap_id  <= grant_id;
            ptr     <= ~grant_id;
         end
         if (state == SHIFT) begin
            out_data <= shifted;
            out_id   <= cap_id;
         end
      end
   end

   Barrel_Shift_R_Gen #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_rot (
      .num     (cap_num),
      .amt     (cap_amt),
      .shifted (shifted)
   );

   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed-vector bench for barrel_shift_arbiter: arbitration, latency, stall, reset abort, rotate sweep.
module tb_barrel_shift_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_num = '0;
   logic [2:0] req0_amt = '0;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_num = '0;
   logic [2:0] req1_amt = '0;
   logic       req1_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_id;
   logic       out_ready = 1'b0;
   logic       busy;

   int n_vec = 0;
   int n_bad = 0;

   // Hand-computed rotate-right of 8'hD7 by 0..7.
   logic [7:0] sweep_exp [8] = '{8'hD7, 8'hEB, 8'hF5, 8'hFA, 8'h7D, 8'hBE, 8'h5F, 8'hAF};

   always #5 clk = ~clk;

   barrel_shift_arbiter #(.WIDTH(8), .AMT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_num   (req0_num),
      .req0_amt   (req0_amt),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_num   (req1_num),
      .req1_amt   (req1_amt),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready0", 32'(req0_ready), 0);
      check("rst_ready1", 32'(req1_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_id", 32'(out_id), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;
   endtask

   // Drives a request, waits (bounded) for its grant, then drops valid after the accept edge.
   task automatic request(input bit id, input logic [7:0] num, input logic [2:0] amt);
      if (id) begin
         req1_valid = 1'b1; req1_num = num; req1_amt = amt;
      end else begin
         req0_valid = 1'b1; req0_num = num; req0_amt = amt;
      end
      #1;
      for (int c = 0; c < 20 && !(id ? req1_ready : req0_ready); c++) begin
         @(negedge clk);
         #1;
      end
      check("grant", 32'(id ? req1_ready : req0_ready), 1);
      check("grant_other", 32'(id ? req0_ready : req1_ready), 0);
      @(posedge clk);
      #1;
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   // Called just after the accept edge T; checks T+1..T+3, optional stall cycles, then handshakes.
   task automatic expect_result(input logic [7:0] data, input bit id, input int hold, input bit early);
      if (early) out_ready = 1'b1;
      @(negedge clk);
      check("lat_t1_valid", 32'(out_valid), 0);
      check("lat_t1_busy", 32'(busy), 1);
      @(negedge clk);
      check("lat_t2_valid", 32'(out_valid), 0);
      @(negedge clk);
      check("t3_valid", 32'(out_valid), 1);
      check("t3_data", 32'(out_data), 32'(data));
      check("t3_id", 32'(out_id), 32'(id));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 1);
         check("hold_data", 32'(out_data), 32'(data));
         check("hold_busy", 32'(busy), 1);
         check("hold_ready", 32'({req0_ready, req1_ready}), 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("after_valid", 32'(out_valid), 0);
   endtask

   task automatic run_op(input bit id, input logic [7:0] num, input logic [2:0] amt,
                         input logic [7:0] data, input bit early);
      request(id, num, amt);
      expect_result(data, id, 0, early);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Single requester, then requester 1 with amt 3 and amt 0.
      reset_dut();
      run_op(1'b0, 8'hD7, 3'd1, 8'hEB, 1'b0);
      run_op(1'b1, 8'hD7, 3'd3, 8'hFA, 1'b0);
      run_op(1'b1, 8'hD7, 3'd0, 8'hD7, 1'b0);

      // Both valid through reset: req0 first, then pointer alternates.
      req0_valid = 1'b1; req0_num = 8'h81; req0_amt = 3'd7;
      req1_valid = 1'b1; req1_num = 8'h81; req1_amt = 3'd4;
      reset_dut();
      #1;
      check("tie_ready0", 32'(req0_ready), 1);
      check("tie_ready1", 32'(req1_ready), 0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      expect_result(8'h03, 1'b0, 0, 1'b0);
      req0_valid = 1'b1;
      #1;
      check("ptr_ready1", 32'(req1_ready), 1);
      check("ptr_ready0", 32'(req0_ready), 0);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      expect_result(8'h18, 1'b1, 0, 1'b0);
      req1_valid = 1'b1;
      #1;
      check("ptr_back_ready0", 32'(req0_ready), 1);
      check("ptr_back_ready1", 32'(req1_ready), 0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      expect_result(8'h03, 1'b0, 0, 1'b0);
      run_op(1'b1, 8'h81, 3'd4, 8'h18, 1'b0);

      // Consumer stalls 5 cycles while req0 waits; req0 must then be served.
      request(1'b1, 8'h3C, 3'd2);
      req0_valid = 1'b1; req0_num = 8'h96; req0_amt = 3'd4;
      expect_result(8'h0F, 1'b1, 5, 1'b0);
      run_op(1'b0, 8'h96, 3'd4, 8'h69, 1'b0);

      // Reset while in SHIFT abandons the operation.
      request(1'b1, 8'hD7, 3'd1);
      @(negedge clk);
      check("abort_load_busy", 32'(busy), 1);
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1; req0_num = 8'h81; req0_amt = 3'd4;
      @(negedge clk);
      check("abort_valid", 32'(out_valid), 0);
      check("abort_data", 32'(out_data), 0);
      check("abort_id", 32'(out_id), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_rst_ready", 32'({req0_ready, req1_ready}), 0);
      rst = 1'b0;
      run_op(1'b0, 8'h81, 3'd4, 8'h18, 1'b0);

      // Rotate sweep; odd amounts hold out_ready high ahead of out_valid.
      for (int a = 0; a < 8; a++) begin
         run_op(1'b0, 8'hD7, 3'(a), sweep_exp[a], a[0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of operands and result.
REQ-002 Parameter AMT_W, default 3, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 has an operation pending.
REQ-006 req0_num  in  WIDTH  requester 0 operand.
REQ-007 req0_amt  in  AMT_W  requester 0 rotate-right amount.
REQ-008 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-009 req1_valid, req1_num, req1_amt, req1_ready SHALL match REQ-005..008 for requester 1.
REQ-010 out_valid  out  1  result available.
REQ-011 out_data  out  WIDTH  rotated result.
REQ-012 out_id  out  1  index of the requester that owns out_data.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT and OUT.
REQ-016 IDLE: with any reqN_valid high, the block SHALL assert ready to exactly one granted requester, capture its num/amt/id and go to LOAD.
REQ-017 Grant rule: a lone valid requester SHALL win; with both valid, the requester selected by the round-robin pointer SHALL win.
REQ-018 After each grant, the pointer SHALL point to the non-granted requester.
REQ-019 reqN_ready SHALL be combinational, high only in IDLE for the granted requester, and never high for both requesters.
REQ-020 Requesters SHALL hold valid, num and amt stable until ready; the block SHALL sample them only on the ready cycle.
REQ-021 LOAD: the captured operands SHALL drive the rotate datapath; state SHALL go to SHIFT.
REQ-022 SHIFT: the datapath output SHALL be registered into out_data; state SHALL go to OUT.
REQ-023 OUT: out_valid SHALL be high, and out_data/out_id SHALL be stable until out_ready.
REQ-024 The out_valid && out_ready cycle SHALL return the FSM to IDLE; a new grant is possible no earlier than the next cycle.
REQ-025 Latency: accept on cycle T SHALL give out_valid on cycle T+3; throughput SHALL be at most one operation per 4 cycles.
REQ-026 Rotation: out_data = (num >> amt) | (num << (WIDTH-amt)) in WIDTH bits.
REQ-027 amt = 0 SHALL return num unchanged with identical latency.
REQ-028 Requests arriving while busy SHALL be stalled (ready low), never dropped or reordered.
REQ-029 Holding out_ready high before out_valid SHALL be legal and SHALL have no effect until OUT.

Reset
REQ-030 On rst: state = IDLE, out_valid = 0, out_data = 0, out_id = 0, busy = 0, pointer = requester 0.
REQ-031 While rst is high, both reqN_ready SHALL be 0.
REQ-032 rst in any state SHALL abandon the in-flight operation; no result SHALL be emitted for it.

Structure
REQ-033 Package barrel_shift_pkg SHALL hold the FSM state encoding and the WIDTH/AMT_W defaults.
REQ-034 The rotate datapath SHALL be one instance of the existing combinational sub-module Barrel_Shift_R_Gen (ports num, amt, shifted).
REQ-035 Arbitration, FSM and output register SHALL live in barrel_shift_arbiter.

Verification
REQ-036 Scenario 1: rst, then req0 num=8'hD7 amt=1 -> req0_ready 1 cycle, out_valid 3 cycles later, out_data=8'hEB, out_id=0.
REQ-037 Scenario 2: req1 num=8'hD7 amt=3, then amt=0 -> 8'hFA then 8'hD7, out_id=1.
REQ-038 Scenario 3: both valid from reset (req0 8'h81/7, req1 8'h81/4) -> req0 served first with 8'h03, then req1 with 8'h18; the pointer then favours req0.
REQ-039 Scenario 4: out_ready held low 5 cycles in OUT -> out_valid/out_data stable throughout, req ready low throughout, busy high.
REQ-040 Scenario 5: rst asserted in SHIFT -> next cycle all outputs at reset values, no out_valid; the following request completes normally.
REQ-041 Scenario 6: sweep amt 0..7 on 8'hD7 from req0 -> each out_data matches REQ-026.
